// File: rtl/dds_sample_capture_pkg.sv
// dds_sample_capture_pkg: capture FSM states, config bit indices and status field positions
package dds_sample_capture_pkg;
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_ARMED = 3'd1, S_CAPTURE = 3'd2, S_DONE = 3'd3} cap_state_e;
  localparam int unsigned CFG_ENABLE = 0;
  localparam int unsigned CFG_ARM = 1;
  localparam int unsigned CFG_TRIG_SEL = 2;
  localparam int unsigned CFG1_LEN_LSB = 0;
  localparam int unsigned CFG1_DEC_LSB = 16;
  localparam int unsigned CFG1_DEC_W = 8;
  localparam int unsigned ST_STATE_LSB = 0;
  localparam int unsigned ST_STATE_W = 3;
  localparam int unsigned ST_OVF = 3;
  localparam int unsigned ST_LERR = 4;
  localparam int unsigned ST_FRAME_LSB = 8;
  localparam int unsigned ST_FRAME_W = 8;
endpackage

// File: rtl/dds_sample_capture_if.sv
// dds_sample_capture_if: 32-bit AXI-Stream channel used for DDS input and capture output
interface dds_sample_capture_if;
  logic [31:0] tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/dds_sample_capture_fifo.sv
// capture_fifo: first-word-fall-through sync FIFO with flush and a "mark newest entry as last" strobe
module capture_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 33
) (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic         flush_i,
  input  logic         wr_i,
  input  logic         rd_i,
  input  logic         mark_last_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_wr, do_rd;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign rdata_o = empty_o ? '0 : mem_q[rp_q];
  always_comb begin
    do_wr = wr_i & ~flush_i;
    do_rd = rd_i & ~empty_o & ~flush_i;
    wp_d = flush_i ? '0 : wp_q + AW'(do_wr);
    rp_d = flush_i ? '0 : rp_q + AW'(do_rd);
    cnt_d = flush_i ? '0 : cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  // The top bit is tlast; a dropped final sample moves tlast onto the newest stored entry.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wp_q] <= wdata_i;
    if (mark_last_i) mem_q[wp_q - 1'b1][W-1] <= 1'b1;
  end
endmodule

// File: rtl/dds_sample_capture.sv
// dds_sample_capture: armed/triggered capture of N DDS samples into an AXI-Stream FIFO.
// Macro DDS_CAPTURE_DECIMATION_EN stores only every (D+1)th accepted sample.
module dds_sample_capture
  import dds_sample_capture_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN_BITS = 15
) (
  input  logic                        clk_i,
  input  logic                        resetn_i,
  input  logic                        trig_i,
  dds_sample_capture_if.slave         s_axis_dds,
  dds_sample_capture_if.master        m_axis_capture,
  input  logic [31:0]                 config_reg_0,
  input  logic [31:0]                 config_reg_1,
  output logic [31:0]                 status_o
);
  cap_state_e state_q, state_d;
  logic arm_q, trig_q, trig_sel_q, trig_sel_d, ovf_q, ovf_d, lerr_q, lerr_d;
  logic [FRAME_LEN_BITS-1:0] n_q, n_d, cnt_q, cnt_d, cnt_inc, n_cfg;
  logic [ST_FRAME_W-1:0] frame_q, frame_d;
  logic enable, arm_edge, trig_edge, go_armed, acc, take, last, full, empty, rd, wr, cfg_unused;
  logic [32:0] rdata;
`ifdef DDS_CAPTURE_DECIMATION_EN
  logic [CFG1_DEC_W-1:0] d_q, d_d, dec_q, dec_d;
`endif
  assign s_axis_dds.tready = resetn_i;
  assign enable = config_reg_0[CFG_ENABLE];
  assign n_cfg = config_reg_1[CFG1_LEN_LSB +: FRAME_LEN_BITS];
  assign arm_edge = config_reg_0[CFG_ARM] & ~arm_q;
  assign trig_edge = trig_i & ~trig_q;
  assign go_armed = state_q == S_IDLE && enable && arm_edge && n_cfg != '0;
  assign acc = s_axis_dds.tvalid & s_axis_dds.tready & enable & (state_q == S_CAPTURE);
`ifdef DDS_CAPTURE_DECIMATION_EN
  assign take = acc & (dec_q == '0);
`else
  assign take = acc;
`endif
  assign cnt_inc = cnt_q + 1'b1;
  assign last = cnt_inc == n_q;
  assign rd = m_axis_capture.tvalid & m_axis_capture.tready;
  assign wr = take & (~full | rd);
  assign m_axis_capture.tvalid = ~empty;
  assign {m_axis_capture.tlast, m_axis_capture.tdata} = rdata;
  assign cfg_unused = ^{config_reg_0, config_reg_1, s_axis_dds.tlast};
  capture_fifo #(.DEPTH(FIFO_DEPTH), .W(33)) u_fifo (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .flush_i     (~enable),
    .wr_i        (wr),
    .rd_i        (rd),
    .mark_last_i (take & last & ~wr),
    .wdata_i     ({last, s_axis_dds.tdata}),
    .rdata_o     (rdata),
    .full_o      (full),
    .empty_o     (empty)
  );
  always_ff @(posedge clk_i or negedge resetn_i)
    if (!resetn_i) begin
      state_q <= S_IDLE;
      arm_q <= 1'b0;
      trig_q <= 1'b0;
      trig_sel_q <= 1'b0;
      ovf_q <= 1'b0;
      lerr_q <= 1'b0;
      n_q <= '0;
      cnt_q <= '0;
      frame_q <= '0;
`ifdef DDS_CAPTURE_DECIMATION_EN
      d_q <= '0;
      dec_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      arm_q <= config_reg_0[CFG_ARM];
      trig_q <= trig_i;
      trig_sel_q <= trig_sel_d;
      ovf_q <= ovf_d;
      lerr_q <= lerr_d;
      n_q <= n_d;
      cnt_q <= cnt_d;
      frame_q <= frame_d;
`ifdef DDS_CAPTURE_DECIMATION_EN
      d_q <= d_d;
      dec_q <= dec_d;
`endif
    end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    state_d = go_armed ? S_ARMED : S_IDLE;
      S_ARMED:   state_d = (!trig_sel_q || trig_edge) ? S_CAPTURE : S_ARMED;
      S_CAPTURE: state_d = (take && last) ? S_DONE : S_CAPTURE;
      S_DONE:    state_d = (empty && !config_reg_0[CFG_ARM]) ? S_IDLE : S_DONE;
      default:   state_d = S_IDLE;
    endcase
    if (!enable) state_d = S_IDLE;
  end
  always_comb begin
    n_d = go_armed ? n_cfg : n_q;
    trig_sel_d = go_armed ? config_reg_0[CFG_TRIG_SEL] : trig_sel_q;
    cnt_d = go_armed ? '0 : take ? cnt_inc : cnt_q;
    ovf_d = go_armed ? 1'b0 : ovf_q | (take & ~wr);
    lerr_d = go_armed ? 1'b0 : (state_q == S_IDLE && enable && arm_edge && n_cfg == '0) ? 1'b1 : lerr_q;
    frame_d = (state_q == S_CAPTURE && state_d == S_DONE) ? frame_q + 1'b1 : frame_q;
`ifdef DDS_CAPTURE_DECIMATION_EN
    d_d = go_armed ? config_reg_1[CFG1_DEC_LSB +: CFG1_DEC_W] : d_q;
    dec_d = go_armed ? '0 : acc ? ((dec_q == d_q) ? '0 : dec_q + 1'b1) : dec_q;
`endif
    status_o = '0;
    status_o[ST_STATE_LSB +: ST_STATE_W] = state_q;
    status_o[ST_OVF] = ovf_q;
    status_o[ST_LERR] = lerr_q;
    status_o[ST_FRAME_LSB +: ST_FRAME_W] = frame_q;
  end
endmodule
